tiamc1_analog_axes: RTL and testbench
=====================================

// Module: tiamc1_analog_axes
// PURPOSE
//  Turns MiSTer hps_io analog controls (stick, paddle, spinner) into NCH
//  absolute position registers that the arcade core reads as a dial/pot.
//  Mode and invert are selected at runtime from OSD status bits.
//  Sits between hps_io and the core's input ports; one clock domain (clk_sys).
// PARAMETERS
//  NCH        2     number of independent axes/channels
//  POS_W      8     position width; centre = 2**(POS_W-1)
//  DEADZONE   16    |stick| <= DEADZONE gives no motion (8-bit signed units)
//  RATE_DIV   4096  clk_sys cycles per joystick integration tick (>=2)
//  JOY_SHIFT  4     joystick step = x >>> JOY_SHIFT per tick
//  DIG_STEP   2     step per tick from digital left/right
//  SPIN_SHIFT 1     spinner delta divided by 2**SPIN_SHIFT; fraction retained
// PORTS
//  clk_sys        in   1          system clock
//  reset_n        in   1          synchronous reset, active-low
//  mode           in   2          0 joystick, 1 paddle, 2 spinner, 3 = joystick
//  invert         in   1          1: negate motion / mirror paddle
//  joy_analog     in   NCH*16     per ch: [7:0] signed X (only X used)
//  joy_dig        in   NCH*2      per ch: [0] right, [1] left
//  paddle         in   NCH*8      unsigned 0..255 absolute
//  spinner        in   NCH*9      per ch: [7:0] signed delta, [8] toggles per new sample
//  vblank         in   1          frame strobe for snapshot
//  pos_live       out  NCH*POS_W  running position, registered
//  pos_frame      out  NCH*POS_W  pos_live captured on vblank rising edge
//  frame_valid    out  1          1-cycle pulse when pos_frame updates
// BEHAVIOUR
//  Reset (reset_n=0 at edge): pos_live = pos_frame = centre, spin frac = 0,
//   tick divider = 0, frame_valid = 0, armed = 0. Reset mid-motion drops all state.
//  Tick: divider counts 0..RATE_DIV-1, tick pulse on wrap; shared by all channels.
//  Joystick (per tick): d = (|x|>DEADZONE ? x>>>JOY_SHIFT : 0)
//   + (right?+DIG_STEP:0) + (left?-DIG_STEP:0); d negated if invert.
//   pos += d in POS_W+2-bit signed arithmetic, saturate to [0, 2**POS_W-1].
//   x = -128 is valid (step -8 with default shift).
//  Paddle: every cycle target = invert ? 255-paddle : paddle; scaled to POS_W
//   (POS_W>8: left-shift, zero fill; POS_W<8: keep MSBs); pos_live = target,
//   1-cycle latency.
//  Spinner: on spinner[8] != stored toggle (armed=1): acc = {pos,frac} +
//   sext(delta) (negated if invert); POS_W+SPIN_SHIFT bits, modulo wrap (no
//   saturation); pos_live = acc MSBs. Update 1 cycle after the toggle edge.
//   armed sets one cycle after reset/mode change; that cycle only loads the stored toggle.
//  Mode change (registered mode differs from input): all channels -> centre,
//   frac = 0, armed = 0, divider = 0; overrides a same-cycle tick/toggle.
//  invert change alone: no re-centre; takes effect on the next update.
//  Snapshot: vblank 0->1 (registered edge detect) copies pos_live to pos_frame
//   and pulses frame_valid for one cycle. If it coincides with an update, the
//   pre-update value is captured.
//  Channels are fully independent apart from the shared tick, mode, invert, vblank.
// STRUCTURE
//  Package tiamc1_analog_pkg: typedef enum logic[1:0] {AM_JOY, AM_PAD, AM_SPIN,
//   AM_RSVD} amode_t; function centre(POS_W); sat/scale helpers.
//  Sub-module tiamc1_analog_axis: one channel (joy/paddle/spin datapath, toggle
//   history, frac accumulator); top holds divider, mode register, vblank edge,
//   snapshot regs, and a generate loop over NCH.
// TESTING (defaults, NCH=2)
//  1 Reset: hold reset_n=0 3 cycles, release -> pos_live=pos_frame=128 both ch,
//   frame_valid=0.
//  2 Joystick: ch0 x=+64, 10 ticks -> pos 168; x=+10 (in deadzone) -> no
//   change; x=+127 run on -> saturates at 255, stays 255; invert=1, x=+64 ->
//   -4/tick.
//  3 Paddle: mode=1, paddle=0x30 -> pos_live=0x30 next cycle; invert=1 ->
//   0xCF; ch1 unaffected by ch0 changes.
//  4 Spinner: mode=2, pos 250, delta=+20 with toggle -> 250+10 wraps to 4;
//   delta=+1 twice -> +1 total (frac carry); no toggle change -> no motion.
//  5 Mode switch: pos 200 in joystick, set mode=2 while spinner[8]=1 -> 128,
//   first cycle ignores the toggle, next toggle counts.
//  6 Snapshot: vblank rise while pos_live changes same cycle -> pos_frame = old
//   value, frame_valid one cycle; vblank held high -> no second pulse.

Source files
------------

// File: rtl/tiamc1_analog_pkg.sv
// Shared types and helpers for the analog-control-to-position block.
package tiamc1_analog_pkg;

    typedef enum logic [1:0] {
        AM_JOY  = 2'd0,
        AM_PAD  = 2'd1,
        AM_SPIN = 2'd2,
        AM_RSVD = 2'd3
    } amode_t;

    function automatic int unsigned centre(input int unsigned pos_w);
        return 32'd1 << (pos_w - 32'd1);
    endfunction

    // Clamp a signed value into [0, 2**pos_w-1]
    function automatic int unsigned sat_u(input int v, input int unsigned pos_w);
        int max_v;
        max_v = int'((32'd1 << pos_w) - 32'd1);
        if (v < 0) return 32'd0;
        if (v > max_v) return 32'(max_v);
        return 32'(v);
    endfunction

    // Map an 8-bit absolute value onto a pos_w-bit range
    function automatic int unsigned scale8(input int unsigned v8, input int unsigned pos_w);
        if (pos_w >= 32'd8) return v8 << (pos_w - 32'd8);
        return v8 >> (32'd8 - pos_w);
    endfunction

endpackage

// File: rtl/tiamc1_analog_axis.sv
// One position channel: joystick integrator, paddle follower and spinner
// accumulator sharing a single {pos, frac} register.
module tiamc1_analog_axis
    import tiamc1_analog_pkg::*;
#(
    parameter int unsigned POS_W      = 8,
    parameter int unsigned DEADZONE   = 16,
    parameter int unsigned JOY_SHIFT  = 4,
    parameter int unsigned DIG_STEP   = 2,
    parameter int unsigned SPIN_SHIFT = 1
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  amode_t           mode,
    input  logic             invert,
    input  logic             tick,
    input  logic             clear,
    input  logic [7:0]       joy_x,
    input  logic             dig_right,
    input  logic             dig_left,
    input  logic [7:0]       paddle,
    input  logic [7:0]       spin_delta,
    input  logic             spin_tog,
    output logic [POS_W-1:0] pos
);

    localparam int unsigned ACC_W = POS_W + SPIN_SHIFT;
    localparam int unsigned SUM_W = POS_W + 2;
    localparam logic [ACC_W-1:0] ACC_CENTRE = ACC_W'(centre(POS_W)) << SPIN_SHIFT;

    logic [ACC_W-1:0]        acc_q, acc_d;
    logic                    tog_q, tog_d;
    logic                    armed_q, armed_d;
    logic signed [8:0]       x_s;
    logic [8:0]              x_mag;
    logic signed [7:0]       x_step;
    logic signed [SUM_W-1:0] joy_d, joy_sum;
    logic [POS_W-1:0]        joy_pos, pad_pos;
    logic [7:0]              pad_t;
    logic signed [ACC_W-1:0] spin_d;

    // Candidate next positions for each mode
    always_comb begin
        x_s    = 9'(signed'(joy_x));
        x_mag  = x_s[8] ? 9'(-x_s) : 9'(x_s);
        x_step = signed'(joy_x) >>> JOY_SHIFT;
        joy_d  = '0;
        if (x_mag > 9'(DEADZONE)) joy_d = SUM_W'(x_step);
        if (dig_right) joy_d = joy_d + $signed(SUM_W'(DIG_STEP));
        if (dig_left)  joy_d = joy_d - $signed(SUM_W'(DIG_STEP));
        if (invert)    joy_d = -joy_d;
        joy_sum = $signed({2'b00, acc_q[ACC_W-1 -: POS_W]}) + joy_d;
        joy_pos = POS_W'(sat_u(int'(joy_sum), POS_W));

        pad_t   = invert ? 8'(8'd255 - paddle) : paddle;
        pad_pos = POS_W'(scale8(32'(pad_t), POS_W));

        spin_d = ACC_W'(signed'(spin_delta));
        if (invert) spin_d = -spin_d;
    end

    // Mode change wins over any same-cycle tick or toggle
    always_comb begin
        acc_d   = acc_q;
        tog_d   = tog_q;
        armed_d = armed_q;
        if (clear) begin
            acc_d   = ACC_CENTRE;
            armed_d = 1'b0;
        end else begin
            tog_d   = spin_tog;
            armed_d = 1'b1;
            case (mode)
                AM_PAD:  acc_d = ACC_W'(pad_pos) << SPIN_SHIFT;
                AM_SPIN: if (armed_q && (spin_tog != tog_q)) acc_d = acc_q + $unsigned(spin_d);
                default: if (tick) acc_d = ACC_W'(joy_pos) << SPIN_SHIFT;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            acc_q   <= ACC_CENTRE;
            tog_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            tog_q   <= tog_d;
            armed_q <= armed_d;
        end
    end

    assign pos = acc_q[ACC_W-1 -: POS_W];

endmodule

// File: rtl/tiamc1_analog_axes.sv
// hps_io analog controls to NCH absolute dial/pot positions with a
// vblank-synchronised snapshot for the core.
module tiamc1_analog_axes
    import tiamc1_analog_pkg::*;
#(
    parameter int unsigned NCH        = 2,
    parameter int unsigned POS_W      = 8,
    parameter int unsigned DEADZONE   = 16,
    parameter int unsigned RATE_DIV   = 4096,
    parameter int unsigned JOY_SHIFT  = 4,
    parameter int unsigned DIG_STEP   = 2,
    parameter int unsigned SPIN_SHIFT = 1
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic [1:0]           mode,
    input  logic                 invert,
    input  logic [NCH*16-1:0]    joy_analog,
    input  logic [NCH*2-1:0]     joy_dig,
    input  logic [NCH*8-1:0]     paddle,
    input  logic [NCH*9-1:0]     spinner,
    input  logic                 vblank,
    output logic [NCH*POS_W-1:0] pos_live,
    output logic [NCH*POS_W-1:0] pos_frame,
    output logic                 frame_valid
);

    localparam int unsigned DIV_W = $clog2(RATE_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RATE_DIV - 1);
    localparam logic [POS_W-1:0] POS_CENTRE = POS_W'(centre(POS_W));

    logic [DIV_W-1:0]     div_q, div_d;
    amode_t               mode_q, mode_d;
    logic                 vblank_q, vblank_d;
    logic [NCH*POS_W-1:0] pos_frame_q, pos_frame_d;
    logic                 frame_valid_q, frame_valid_d;
    logic                 mode_chg, tick, vb_rise;

    // Shared tick, mode-change detect and snapshot of the pre-update positions
    always_comb begin
        mode_d        = amode_t'(mode);
        mode_chg      = (mode_d != mode_q);
        tick          = (div_q == DIV_LAST);
        div_d         = (mode_chg || tick) ? '0 : div_q + DIV_W'(1);
        vblank_d      = vblank;
        vb_rise       = vblank & ~vblank_q;
        pos_frame_d   = vb_rise ? pos_live : pos_frame_q;
        frame_valid_d = vb_rise;
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            div_q         <= '0;
            mode_q        <= AM_JOY;
            vblank_q      <= 1'b0;
            pos_frame_q   <= {NCH{POS_CENTRE}};
            frame_valid_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            mode_q        <= mode_d;
            vblank_q      <= vblank_d;
            pos_frame_q   <= pos_frame_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    assign pos_frame   = pos_frame_q;
    assign frame_valid = frame_valid_q;

    for (genvar g = 0; g < NCH; g++) begin : g_axis
        tiamc1_analog_axis #(
            .POS_W      (POS_W),
            .DEADZONE   (DEADZONE),
            .JOY_SHIFT  (JOY_SHIFT),
            .DIG_STEP   (DIG_STEP),
            .SPIN_SHIFT (SPIN_SHIFT)
        ) u_axis (
            .clk_sys    (clk_sys),
            .reset_n    (reset_n),
            .mode       (mode_q),
            .invert     (invert),
            .tick       (tick),
            .clear      (mode_chg),
            .joy_x      (joy_analog[g*16 +: 8]),
            .dig_right  (joy_dig[g*2]),
            .dig_left   (joy_dig[g*2+1]),
            .paddle     (paddle[g*8 +: 8]),
            .spin_delta (spinner[g*9 +: 8]),
            .spin_tog   (spinner[g*9+8]),
            .pos        (pos_live[g*POS_W +: POS_W])
        );
    end

endmodule

// File: tb/tb_tiamc1_analog_axes.sv
// Self-checking bench: directed sequences and a paddle table with constant
// expectations, plus randomized traffic against an integer reference model.
module tb_tiamc1_analog_axes;

    localparam int NCH   = 2;
    localparam int POS_W = 8;
    localparam int RATE  = 64;
    localparam int S     = 1;
    localparam int SC    = 1 << S;
    localparam int MODV  = 1 << (POS_W + S);

    logic                 clk_sys = 1'b0;
    logic                 reset_n;
    logic [1:0]           mode;
    logic                 invert;
    logic [NCH*16-1:0]    joy_analog;
    logic [NCH*2-1:0]     joy_dig;
    logic [NCH*8-1:0]     paddle;
    logic [NCH*9-1:0]     spinner;
    logic                 vblank;
    logic [NCH*POS_W-1:0] pos_live;
    logic [NCH*POS_W-1:0] pos_frame;
    logic                 frame_valid;

    always #5 clk_sys = ~clk_sys;

    tiamc1_analog_axes #(.NCH(NCH), .POS_W(POS_W), .RATE_DIV(RATE)) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .mode        (mode),
        .invert      (invert),
        .joy_analog  (joy_analog),
        .joy_dig     (joy_dig),
        .paddle      (paddle),
        .spinner     (spinner),
        .vblank      (vblank),
        .pos_live    (pos_live),
        .pos_frame   (pos_frame),
        .frame_valid (frame_valid)
    );

    // Reference model state: acc is position scaled by 2**S (fraction kept)
    int m_acc[NCH];
    int m_frame[NCH];
    int m_tog[NCH];
    int m_armed[NCH];
    int m_fv, m_div, m_mode, m_vb;
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] p0;
        logic [7:0] p1;
        logic       inv;
        logic [7:0] e0;
        logic [7:0] e1;
    } pad_vec_t;
    pad_vec_t pv[7];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int clampi(input int v);
        if (v < 0) return 0;
        if (v > (1 << POS_W) - 1) return (1 << POS_W) - 1;
        return v;
    endfunction

    task automatic model_step();
        int x, d, dl, p, em;
        bit tick, rise, tg;
        if (!reset_n) begin
            for (int ch = 0; ch < NCH; ch++) begin
                m_acc[ch] = 128 * SC; m_frame[ch] = 128; m_tog[ch] = 0; m_armed[ch] = 0;
            end
            m_fv = 0; m_div = 0; m_mode = 0; m_vb = 0;
        end else begin
            rise = vblank && (m_vb == 0);
            m_fv = rise ? 1 : 0;
            for (int ch = 0; ch < NCH; ch++) if (rise) m_frame[ch] = m_acc[ch] / SC;
            m_vb = int'(vblank);
            if (int'(mode) != m_mode) begin
                m_mode = int'(mode);
                m_div  = 0;
                for (int ch = 0; ch < NCH; ch++) begin
                    m_acc[ch] = 128 * SC; m_armed[ch] = 0;
                end
            end else begin
                tick  = (m_div == RATE - 1);
                m_div = tick ? 0 : m_div + 1;
                em    = (m_mode == 3) ? 0 : m_mode;
                for (int ch = 0; ch < NCH; ch++) begin
                    tg = spinner[ch*9+8];
                    if (em == 1) begin
                        p = int'(paddle[ch*8 +: 8]);
                        m_acc[ch] = (invert ? 255 - p : p) * SC;
                    end else if (em == 2) begin
                        if (m_armed[ch] != 0 && m_tog[ch] != int'(tg)) begin
                            dl = int'($signed(spinner[ch*9 +: 8]));
                            if (invert) dl = -dl;
                            m_acc[ch] = ((m_acc[ch] + dl) % MODV + MODV) % MODV;
                        end
                    end else if (tick) begin
                        x = int'($signed(joy_analog[ch*16 +: 8]));
                        d = 0;
                        if ((x < 0 ? -x : x) > 16) d = x >>> 4;
                        if (joy_dig[ch*2])   d += 2;
                        if (joy_dig[ch*2+1]) d -= 2;
                        if (invert) d = -d;
                        m_acc[ch] = clampi(m_acc[ch] / SC + d) * SC;
                    end
                    m_tog[ch] = int'(tg);
                    m_armed[ch] = 1;
                end
            end
        end
    endtask

    // One clock: advance the model on the current inputs, then compare
    task automatic cyc();
        model_step();
        @(posedge clk_sys);
        #1;
        for (int ch = 0; ch < NCH; ch++) begin
            chk($sformatf("model_live%0d", ch), int'(pos_live[ch*POS_W +: POS_W]), m_acc[ch] / SC);
            chk($sformatf("model_frame%0d", ch), int'(pos_frame[ch*POS_W +: POS_W]), m_frame[ch]);
        end
        chk("model_fv", int'(frame_valid), m_fv);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    function automatic int live(input int ch);
        return int'(pos_live[ch*POS_W +: POS_W]);
    endfunction

    task automatic set_spin(input int ch, input logic [7:0] dl, input logic tg);
        spinner[ch*9 +: 9] = {tg, dl};
    endtask

    initial begin
        pv[0] = '{8'h30, 8'h80, 1'b0, 8'h30, 8'h80};
        pv[1] = '{8'h30, 8'h80, 1'b1, 8'hCF, 8'h7F};
        pv[2] = '{8'h31, 8'h80, 1'b1, 8'hCE, 8'h7F};
        pv[3] = '{8'h00, 8'h80, 1'b0, 8'h00, 8'h80};
        pv[4] = '{8'hFF, 8'h80, 1'b0, 8'hFF, 8'h80};
        pv[5] = '{8'h00, 8'h21, 1'b0, 8'h00, 8'h21};
        pv[6] = '{8'h55, 8'h12, 1'b1, 8'hAA, 8'hED};

        reset_n = 1'b0; mode = 2'd0; invert = 1'b0; joy_analog = '0; joy_dig = '0;
        paddle = '0; spinner = '0; vblank = 1'b0;

        // Reset state
        run(3);
        chk("rst_live0", live(0), 128);
        chk("rst_live1", live(1), 128);
        chk("rst_frame", int'(pos_frame), 16'h8080);
        chk("rst_fv", int'(frame_valid), 0);
        reset_n = 1'b1;

        // Joystick integration, deadzone, saturation, invert, full-negative X
        joy_analog[7:0] = 8'd64;
        run(10 * RATE);
        chk("joy_10tick", live(0), 168);
        chk("joy_ch1_idle", live(1), 128);
        joy_analog[7:0] = 8'd10;
        run(3 * RATE);
        chk("joy_deadzone", live(0), 168);
        joy_analog[7:0] = 8'd127;
        run(20 * RATE);
        chk("joy_sat", live(0), 255);
        invert = 1'b1; joy_analog[7:0] = 8'd64;
        run(RATE);
        chk("joy_invert", live(0), 251);
        invert = 1'b0; joy_analog[7:0] = 8'h80;
        run(2 * RATE);
        chk("joy_m128", live(0), 235);
        joy_analog = '0;

        // Paddle table
        mode = 2'd1; paddle = 16'h8030;
        cyc();
        chk("pad_recentre", live(0), 128);
        foreach (pv[i]) begin
            paddle = {pv[i].p1, pv[i].p0}; invert = pv[i].inv;
            cyc();
            chk($sformatf("pad_vec%0d_ch0", i), live(0), int'(pv[i].e0));
            chk($sformatf("pad_vec%0d_ch1", i), live(1), int'(pv[i].e1));
        end
        invert = 1'b0;

        // Spinner: wrap, fractional carry, idle toggle
        mode = 2'd2; spinner = '0;
        cyc();
        chk("spin_recentre", live(0), 128);
        cyc();
        set_spin(0, 8'd122, 1'b1); cyc();
        set_spin(0, 8'd122, 1'b0); cyc();
        chk("spin_250", live(0), 250);
        set_spin(0, 8'd20, 1'b1); cyc();
        chk("spin_wrap", live(0), 4);
        set_spin(0, 8'd1, 1'b0); cyc();
        chk("spin_frac1", live(0), 4);
        set_spin(0, 8'd1, 1'b1); cyc();
        chk("spin_frac2", live(0), 5);
        run(5);
        chk("spin_idle", live(0), 5);
        chk("spin_ch1", live(1), 128);

        // Mode switch re-centres and the first cycle only arms the toggle
        mode = 2'd0; set_spin(0, 8'd10, 1'b0);
        cyc();
        joy_analog[7:0] = 8'd64;
        run(18 * RATE);
        chk("sw_joy200", live(0), 200);
        joy_analog = '0;
        mode = 2'd2; set_spin(0, 8'd10, 1'b1);
        cyc();
        chk("sw_centre", live(0), 128);
        cyc();
        chk("sw_arm_ignored", live(0), 128);
        set_spin(0, 8'd10, 1'b0); cyc();
        chk("sw_next_toggle", live(0), 133);

        // Snapshot takes the pre-update value; held vblank gives one pulse
        mode = 2'd1; paddle = 16'h1240;
        run(2);
        vblank = 1'b1; paddle = 16'h1241;
        cyc();
        chk("snap_live", live(0), 8'h41);
        chk("snap_frame_old", int'(pos_frame[7:0]), 8'h40);
        chk("snap_fv", int'(frame_valid), 1);
        cyc();
        chk("snap_fv_once", int'(frame_valid), 0);
        run(3);
        chk("snap_held", int'(frame_valid), 0);
        vblank = 1'b0; cyc();
        vblank = 1'b1; cyc();
        chk("snap_again_fv", int'(frame_valid), 1);
        chk("snap_again_frame", int'(pos_frame[7:0]), 8'h41);
        vblank = 1'b0;

        // Reset mid-motion
        reset_n = 1'b0; cyc();
        chk("midrst_live", live(0), 128);
        chk("midrst_frame", int'(pos_frame[7:0]), 128);
        reset_n = 1'b1;

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) invert = ~invert;
            if ($urandom_range(0, 15) == 0) joy_analog = 32'($urandom());
            if ($urandom_range(0, 15) == 0) joy_dig = 4'($urandom());
            if ($urandom_range(0, 3) == 0) paddle = 16'($urandom());
            for (int ch = 0; ch < NCH; ch++)
                if ($urandom_range(0, 3) == 0)
                    set_spin(ch, 8'($urandom()), ~spinner[ch*9+8]);
            if ($urandom_range(0, 9) == 0) vblank = ~vblank;
            reset_n = ($urandom_range(0, 999) != 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
